cmos_axi_word_packer: RTL

Per-camera pixel packer sitting directly upstream of the frame-buffer write FIFO / AXI write master in the stitching datapath. It runs in the camera pixel clock domain and converts the 24-bit CMOS stream (vsync/href/clken/data) into dense 128-bit memory words. Packing is little-endian and gap-free: 16 pixels produce exactly 3 words. Each word is tagged with start-of-frame and end-of-line so the write side can compute burst addresses.

---
 rtl/stitch_pkg.sv | 20 ++
 rtl/byte_accum.sv | 87 ++++++++
 rtl/cmos_axi_word_packer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/stitch_pkg.sv
// Shared constants, state type and line-size helper for the stitching pixel datapath.
package stitch_pkg;

  localparam int PIX_BYTES       = 3;
  localparam int WORD_BYTES      = 16;
  localparam int PIX_PER_GROUP   = 16;
  localparam int WORDS_PER_GROUP = 3;

  typedef enum logic {
    IDLE,
    ACTIVE
  } pack_state_t;

  // Whole 16-pixel groups plus the padded tail word of a line.
  function automatic int words_per_line(input int hdisp);
    return (hdisp / PIX_PER_GROUP) * WORDS_PER_GROUP
         + ((hdisp % PIX_PER_GROUP) * PIX_BYTES + WORD_BYTES - 1) / WORD_BYTES;
  endfunction

endpackage

// File: rtl/byte_accum.sv
// Byte accumulator: merges pixel bytes into output words, carries leftovers,
// and zero-pads a partial word on flush (a padded tail may follow one cycle later).
module byte_accum
  import stitch_pkg::*;
#(
  parameter int PIX_W  = 24,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic              flush,
  input  logic [PIX_W-1:0]  pix,
  output logic              word_valid,
  output logic [DATA_W-1:0] word_data,
  output logic              word_eol
);

  localparam int PB = PIX_W / 8;
  localparam int WB = DATA_W / 8;
  localparam int FW = $clog2(WB);

  logic [FW-1:0]       fill, fill_nxt;
  logic [DATA_W-1:0]   acc, acc_nxt;
  logic                flush_pend, pend_nxt;
  logic [2*DATA_W-1:0] merged;
  logic [FW:0]         total, left;
  logic                complete;

  always_comb begin
    merged = {{DATA_W{1'b0}}, acc};
    total  = {1'b0, fill};
    if (push) begin
      merged = merged | ({{(2*DATA_W-PIX_W){1'b0}}, pix} << {fill, 3'b000});
      total  = {1'b0, fill} + (FW+1)'(PB);
    end
    complete   = (total >= (FW+1)'(WB));
    left       = total - (FW+1)'(WB);
    word_valid = 1'b0;
    word_data  = merged[DATA_W-1:0];
    word_eol   = 1'b0;
    fill_nxt   = fill;
    acc_nxt    = acc;
    pend_nxt   = 1'b0;
    if (clear) begin
      fill_nxt = '0;
      acc_nxt  = '0;
    end else if (flush_pend) begin
      word_valid = 1'b1;
      word_data  = acc;
      word_eol   = 1'b1;
      fill_nxt   = '0;
      acc_nxt    = '0;
    end else if (complete) begin
      word_valid = 1'b1;
      acc_nxt    = merged[2*DATA_W-1:DATA_W];
      fill_nxt   = left[FW-1:0];
      // A flush that also completes a word defers the leftover bytes to a second padded word.
      if (flush) begin
        if (left == '0) word_eol = 1'b1;
        else            pend_nxt = 1'b1;
      end
    end else if (flush) begin
      word_valid = (total != '0);
      word_eol   = 1'b1;
      fill_nxt   = '0;
      acc_nxt    = '0;
    end else begin
      fill_nxt = total[FW-1:0];
      acc_nxt  = merged[DATA_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill       <= '0;
      acc        <= '0;
      flush_pend <= 1'b0;
    end else begin
      fill       <= fill_nxt;
      acc        <= acc_nxt;
      flush_pend <= pend_nxt;
    end
  end

endmodule

// File: rtl/cmos_axi_word_packer.sv
// Packs the 24-bit CMOS pixel stream into dense little-endian memory words
// tagged with start-of-frame and end-of-line.
//   state  | meaning
//   IDLE   | outside the vsync active window, pixels ignored
//   ACTIVE | frame in progress, pixels accepted and packed
module cmos_axi_word_packer
  import stitch_pkg::*;
#(
  parameter int PIX_W     = 24,
  parameter int DATA_W    = 128,
  parameter int IMG_HDISP = 1920,
  parameter bit VSYNC_POL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmos_vsync,
  input  logic              cmos_href,
  input  logic              cmos_clken,
  input  logic [PIX_W-1:0]  cmos_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sof,
  output logic              out_eol,
  input  logic              err_clr,
  output logic              err_ovf,
  output logic              err_line
);

  localparam int             CW   = $clog2(IMG_HDISP + 1);
  localparam logic [CW-1:0]  LAST = CW'(IMG_HDISP - 1);
  localparam logic [CW-1:0]  FULL = CW'(IMG_HDISP);

  pack_state_t       state, state_nxt;
  logic              vs_act, vs_act_d, vs_start, vs_end;
  logic              href_d, href_fall;
  logic [CW-1:0]     pix_cnt;
  logic              pix_ok, accept, extra, last_pix, short_line;
  logic              sof_pend, load, drop;
  logic              word_valid, word_eol;
  logic [DATA_W-1:0] word_data;

  assign vs_act     = (cmos_vsync == VSYNC_POL);
  assign vs_start   = vs_act & ~vs_act_d;
  assign vs_end     = ~vs_act & vs_act_d;
  assign href_fall  = href_d & ~cmos_href;
  assign pix_ok     = (state == ACTIVE) & cmos_href & cmos_clken & ~vs_start;
  assign accept     = pix_ok & (pix_cnt != FULL);
  assign extra      = pix_ok & (pix_cnt == FULL);
  assign last_pix   = accept & (pix_cnt == LAST);
  assign short_line = (state == ACTIVE) & href_fall & ~vs_start
                    & (pix_cnt != '0) & (pix_cnt != FULL);
  assign drop       = word_valid & out_valid & ~out_ready;
  assign load       = word_valid & ~drop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (vs_start) state_nxt = ACTIVE;
      ACTIVE:  if (vs_end)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  byte_accum #(.PIX_W(PIX_W), .DATA_W(DATA_W)) u_accum (
    .clk        (clk),
    .rst        (rst),
    .clear      (vs_start),
    .push       (accept),
    .flush      (last_pix | short_line),
    .pix        (cmos_data),
    .word_valid (word_valid),
    .word_data  (word_data),
    .word_eol   (word_eol)
  );

  // vs_act_d resets high so a vsync already active at reset release does not start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vs_act_d <= 1'b1;
      href_d   <= 1'b0;
      pix_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      vs_act_d <= vs_act;
      href_d   <= cmos_href;
      if (vs_start || href_fall) pix_cnt <= '0;
      else if (accept)           pix_cnt <= pix_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eol   <= 1'b0;
      sof_pend  <= 1'b0;
      err_ovf   <= 1'b0;
      err_line  <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= word_data;
        out_sof   <= sof_pend;
        out_eol   <= word_eol;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_eol   <= 1'b0;
      end
      if (vs_start)  sof_pend <= 1'b1;
      else if (load) sof_pend <= 1'b0;
      err_ovf  <= drop | (err_ovf & ~err_clr);
      err_line <= short_line | extra | (err_line & ~err_clr);
    end
  end

endmodule
